mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Parametrised multi-cycle multiply/divide unit that owns the architectural HI/LO registers of the pipelined CPU.
- Replaces the single-cycle combinational mult/div path with WIDTH-iteration shift-add multiply and restoring divide.
- Uses a start/busy/done handshake; the EX stage stalls while busy is high.
- Provides a flush input so an interrupt or exception can kill an in-flight operation without corrupting HI/LO.

Parameters:
- WIDTH, 32, operand width in bits; must be even and at least 4. HI and LO are each WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled only in IDLE.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src0_i  in  WIDTH  multiplicand or dividend (rs).
- src1_i  in  WIDTH  multiplier or divisor (rt).
- flush  in  1  abort the current operation (interrupt or exception).
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata_i  in  WIDTH  data for MTHI/MTLO.
- hi_o  out  WIDTH  HI register.
- lo_o  out  WIDTH  LO register.
- busy  out  1  operation in progress (CALC or FIX).
- done  out  1  one-cycle pulse when HI/LO are updated by an operation.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE; hi_o=0, lo_o=0, busy=0, done=0; all internal registers cleared.
  - Reset applied mid-operation discards the operation and produces no done.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 latches op and operands, clears the counter, and moves to CALC.
  - For signed ops (MULT, DIV), the magnitudes |src0| and |src1| are latched, plus the result-sign flags:
    - product/quotient negative = src0[MSB] XOR src1[MSB];
    - remainder negative = src0[MSB].
- CALC, one iteration per cycle, WIDTH cycles, then FIX:
  - Multiply: 2*WIDTH-bit accumulator; add the shifted multiplicand when the current multiplier LSB is 1, then shift.
  - Divide: restoring divide; shift {rem,quo} left, trial-subtract the divisor, and set the quotient bit when no borrow occurs.
- FIX (one cycle), then IDLE:
  - Apply two's-complement negation per the sign flags.
  - Write HI = product[2W-1:W] or remainder; write LO = product[W-1:0] or quotient.
  - done=1 in the following cycle, concurrent with IDLE.
- Latency:
  - start sampled at edge E0.
  - busy=1 from after E0 through edge E0+WIDTH+1.
  - HI/LO updated and done=1 after edge E0+WIDTH+1, i.e. WIDTH+1 cycles after the start edge.
  - done is low at all other times.
- busy is registered and equals (state!=IDLE).
- Arithmetic rules:
  - All results are modulo 2^WIDTH per half.
  - MULT is exact signed 2W-bit; MULTU is exact unsigned 2W-bit.
  - Signed divide truncates toward zero.
  - Most-negative / -1: LO=most-negative (1<<(W-1)), HI=0.
- Divide by zero (DIV or DIVU, src1=0):
  - No trap; LO=all ones, HI=src0 unchanged (the raw dividend, not its magnitude).
  - Latency is the same as a normal divide.
- start while busy: ignored, not queued.
- flush:
  - In CALC or FIX, flush returns to IDLE at the next edge; HI/LO are unchanged and done stays 0.
  - flush in IDLE blocks a simultaneous start.
  - flush has priority over FIX completion in the same cycle.
- MTHI/MTLO:
  - In IDLE with start=0 and flush=0, hi_we/lo_we write wdata_i at the next edge; both may be asserted together.
  - Writes are ignored while busy.
  - Writes are ignored when start=1 in the same cycle (start wins).
  - A flush in IDLE also discards the write.
- Outputs hi_o/lo_o are held stable except on a FIX commit, an MT write, or reset.

Test Plan:
- MULT src0=0xFFFFFFFD (-3), src1=5 -> done 33 cycles after the start edge (WIDTH=32); HI=0xFFFFFFFF, LO=0xFFFFFFF1; busy high exactly 33 cycles.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; DIVU 7/0 -> LO=0xFFFFFFFF, HI=0x00000007.
- Preload HI=0x1234 via MTHI; start DIVU 100/7; assert flush at CALC cycle 10 -> busy drops the next cycle, no done, HI=0x1234 unchanged; a new start is accepted immediately.
- start pulses and lo_we=1 while busy -> ignored; result of the first op only. start+lo_we in the same IDLE cycle -> op runs and LO is not written. flush+start in IDLE -> nothing starts.
- rst asserted mid-CALC -> next cycle hi_o=lo_o=0, busy=0, done=0. Rerun MULT with WIDTH=8: 0x80*0x80 signed -> HI=0x40, LO=0x00, done 9 cycles after the start edge.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
// Shift-add multiply and restoring divide, one iteration per clock, WIDTH iterations.
module mdu_iter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src0_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic             flush,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t               r_state;
   logic                 r_isDiv;
   logic                 r_negQ;
   logic                 r_negR;
   logic                 r_divZero;
   logic [WIDTH-1:0]     r_operand;
   logic [WIDTH-1:0]     r_dividendRaw;
   logic [2*WIDTH-1:0]   r_acc;
   logic [CNT_W-1:0]     r_cnt;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;
   logic                 r_busy;
   logic                 r_done;

   logic                 w_signed;
   logic [WIDTH-1:0]     w_abs0;
   logic [WIDTH-1:0]     w_abs1;
   logic [WIDTH:0]       w_mulSum;
   logic [2*WIDTH-1:0]   w_mulNext;
   logic [WIDTH:0]       w_divShift;
   logic [WIDTH:0]       w_divDiff;
   logic [2*WIDTH-1:0]   w_divNext;
   logic [2*WIDTH-1:0]   w_prodFix;
   logic [WIDTH-1:0]     w_quoFix;
   logic [WIDTH-1:0]     w_remFix;

   // Signed ops iterate on magnitudes; the sign is reapplied in FIX.
   assign w_signed = ~op[0];
   assign w_abs0   = (w_signed && src0_i[WIDTH-1]) ? -src0_i : src0_i;
   assign w_abs1   = (w_signed && src1_i[WIDTH-1]) ? -src1_i : src1_i;

   // Multiply: upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
   assign w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_operand : {WIDTH{1'b0}})};
   assign w_mulNext = {w_mulSum, r_acc[WIDTH-1:1]};

   // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
   assign w_divShift = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_divDiff  = w_divShift - {1'b0, r_operand};
   assign w_divNext  = {(w_divDiff[WIDTH] ? w_divShift[WIDTH-1:0] : w_divDiff[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], ~w_divDiff[WIDTH]};

   assign w_prodFix = r_negQ ? -r_acc : r_acc;
   assign w_quoFix  = r_negQ ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_remFix  = r_negR ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_isDiv       <= 1'b0;
         r_negQ        <= 1'b0;
         r_negR        <= 1'b0;
         r_divZero     <= 1'b0;
         r_operand     <= '0;
         r_dividendRaw <= '0;
         r_acc         <= '0;
         r_cnt         <= '0;
         r_hi          <= '0;
         r_lo          <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!flush && start) begin
                  r_isDiv       <= op[1];
                  r_negQ        <= w_signed & (src0_i[WIDTH-1] ^ src1_i[WIDTH-1]);
                  r_negR        <= w_signed & src0_i[WIDTH-1];
                  r_divZero     <= op[1] & (src1_i == '0);
                  r_dividendRaw <= src0_i;
                  r_operand     <= op[1] ? w_abs1 : w_abs0;
                  r_acc         <= {{WIDTH{1'b0}}, (op[1] ? w_abs0 : w_abs1)};
                  r_cnt         <= '0;
                  r_state       <= CALC;
                  r_busy        <= 1'b1;
               end else if (!flush) begin
                  if (hi_we) r_hi <= wdata_i;
                  if (lo_we) r_lo <= wdata_i;
               end
            end
            CALC: begin
               if (flush) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_acc <= r_isDiv ? w_divNext : w_mulNext;
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= FIX;
               end
            end
            FIX: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               if (!flush) begin
                  r_done <= 1'b1;
                  if (!r_isDiv) begin
                     r_hi <= w_prodFix[2*WIDTH-1:WIDTH];
                     r_lo <= w_prodFix[WIDTH-1:0];
                  end else if (r_divZero) begin
                     r_hi <= r_dividendRaw;
                     r_lo <= {WIDTH{1'b1}};
                  end else begin
                     r_hi <= w_remFix;
                     r_lo <= w_quoFix;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign hi_o = r_hi;
   assign lo_o = r_lo;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: scoreboard of expected HI/LO results popped on done,
// plus directed checks of latency, flush, MTHI/MTLO, reset and a WIDTH=8 instance.
module tb_mdu_iter;
   localparam int W = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src0;
   logic [31:0] src1;
   logic        flush;
   logic        hiWe;
   logic        loWe;
   logic [31:0] wdata;
   logic [31:0] hiO;
   logic [31:0] loO;
   logic        busy;
   logic        done;

   logic        start8;
   logic [7:0]  a8;
   logic [7:0]  b8;
   logic [7:0]  hi8;
   logic [7:0]  lo8;
   logic        busy8;
   logic        done8;

   int          nAsserts = 0;
   int          nFails = 0;
   logic [63:0] expQ[$];
   string       tagQ[$];

   always #5 clk = ~clk;

   mdu_iter #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .src0_i(src0), .src1_i(src1),
      .flush(flush), .hi_we(hiWe), .lo_we(loWe), .wdata_i(wdata),
      .hi_o(hiO), .lo_o(loO), .busy(busy), .done(done)
   );

   mdu_iter #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .op(2'b00), .src0_i(a8), .src1_i(b8),
      .flush(1'b0), .hi_we(1'b0), .lo_we(1'b0), .wdata_i(8'h00),
      .hi_o(hi8), .lo_o(lo8), .busy(busy8), .done(done8)
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Independent reference for HI/LO using wide native arithmetic.
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] ua, ub;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (o)
         2'b00: model = 64'(sa * sb);
         2'b01: model = ua * ub;
         default: begin
            if (b == 32'd0) model = {a, 32'hFFFFFFFF};
            else if (o == 2'b10) begin
               q = sa / sb;
               r = sa % sb;
               model = {r[31:0], q[31:0]};
            end else model = {32'(ua % ub), 32'(ua / ub)};
         end
      endcase
   endfunction

   // Scoreboard consumer: every done pops one expectation; a done with nothing queued is an error.
   always @(negedge clk) begin : monitor
      logic [63:0] e;
      string       t;
      if (!rst && done) begin
         if (expQ.size() == 0) checkOutput("spurious_done", {63'd0, done}, 64'd0);
         else begin
            e = expQ.pop_front();
            t = tagQ.pop_front();
            checkOutput(t, {hiO, loO}, e);
         end
      end
   end

   // mode 0: plain op; mode 1: start+loWe pulse while busy; mode 2: loWe together with start.
   task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [63:0] exp, input string tag, input int mode);
      int lat;
      int busyCnt;
      lat = -1;
      busyCnt = 0;
      @(posedge clk); #1;
      op = o; src0 = a; src1 = b; start = 1'b1;
      if (mode == 2) begin loWe = 1'b1; wdata = 32'hBAD0BAD0; end
      expQ.push_back(exp);
      tagQ.push_back(tag);
      @(posedge clk); #1;
      start = 1'b0; loWe = 1'b0;
      for (int k = 0; k < W + 6; k++) begin
         @(negedge clk);
         if (mode == 1 && k == 5) begin
            start = 1'b1; op = 2'b01; src0 = 32'h55; src1 = 32'h3; loWe = 1'b1; wdata = 32'hDEAD;
         end
         if (mode == 1 && k == 6) begin start = 1'b0; loWe = 1'b0; end
         if (busy) busyCnt++;
         if (done) begin lat = k; break; end
      end
      checkOutput({tag, "_latency"}, 64'(lat), 64'(W + 1));
      checkOutput({tag, "_busycycles"}, 64'(busyCnt), 64'(W + 1));
   endtask

   initial begin : watchdog
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin : stimulus
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      int          lat8;

      rst = 1'b1; start = 1'b0; op = 2'b00; src0 = '0; src1 = '0; flush = 1'b0;
      hiWe = 1'b0; loWe = 1'b0; wdata = '0; start8 = 1'b0; a8 = '0; b8 = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_hi", hiO, 64'd0);
      checkOutput("reset_lo", loO, 64'd0);
      checkOutput("reset_busy", busy, 64'd0);
      checkOutput("reset_done", done, 64'd0);
      rst = 1'b0;

      applyStimulus(2'b00, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, "mult_neg3x5", 0);
      applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, "multu_max", 0);
      applyStimulus(2'b10, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, "div_neg7by2", 0);
      applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, "div_minbyneg1", 0);
      applyStimulus(2'b11, 32'd7, 32'd0, 64'h00000007_FFFFFFFF, "divu_by0", 0);
      applyStimulus(2'b10, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF, "div_neg_by0", 0);

      for (int i = 0; i < 4; i++) begin
         ro = 2'(i);
         ra = $urandom;
         rb = (i >= 2) ? 32'($urandom_range(1, 5000)) : $urandom;
         applyStimulus(ro, ra, rb, model(ro, ra, rb), $sformatf("rand%0d", i), 0);
      end

      // MTHI/MTLO together, then MTHI alone.
      @(posedge clk); #1; hiWe = 1'b1; loWe = 1'b1; wdata = 32'hCAFE;
      @(posedge clk); #1; hiWe = 1'b0; loWe = 1'b0;
      checkOutput("mt_both_hi", hiO, 64'hCAFE);
      checkOutput("mt_both_lo", loO, 64'hCAFE);
      @(posedge clk); #1; hiWe = 1'b1; wdata = 32'h1234;
      @(posedge clk); #1; hiWe = 1'b0;
      checkOutput("mthi_hi", hiO, 64'h1234);
      checkOutput("mthi_lo_kept", loO, 64'hCAFE);

      // Flush an in-flight DIVU during CALC.
      @(posedge clk); #1; op = 2'b11; src0 = 32'd100; src1 = 32'd7; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (10) @(posedge clk);
      #1; flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      @(negedge clk);
      checkOutput("flush_busy", busy, 64'd0);
      checkOutput("flush_hi", hiO, 64'h1234);
      repeat (W + 4) @(negedge clk);
      checkOutput("flush_lo", loO, 64'hCAFE);
      applyStimulus(2'b11, 32'd100, 32'd7, 64'h00000002_0000000E, "divu_after_flush", 0);

      applyStimulus(2'b01, 32'd6, 32'd7, 64'h00000000_0000002A, "multu_disturbed", 1);
      applyStimulus(2'b10, 32'd100, 32'hFFFFFFF9, model(2'b10, 32'd100, 32'hFFFFFFF9), "div_start_lowe", 2);

      // flush+start (+MTHI) in IDLE: nothing starts, nothing is written.
      @(posedge clk); #1; start = 1'b1; flush = 1'b1; hiWe = 1'b1; wdata = 32'h9999; op = 2'b01;
      src0 = 32'd5; src1 = 32'd5;
      @(posedge clk); #1; start = 1'b0; flush = 1'b0; hiWe = 1'b0;
      @(negedge clk);
      checkOutput("flushstart_busy", busy, 64'd0);
      repeat (W + 4) @(negedge clk);
      checkOutput("flushstart_hilo", {hiO, loO}, 64'h00000002_FFFFFFF2);

      // Reset in the middle of CALC.
      @(posedge clk); #1; op = 2'b00; src0 = 32'd3; src1 = 32'd3; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (5) @(posedge clk);
      #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      checkOutput("midreset_hi", hiO, 64'd0);
      checkOutput("midreset_lo", loO, 64'd0);
      checkOutput("midreset_busy", busy, 64'd0);
      checkOutput("midreset_done", done, 64'd0);
      repeat (W + 4) @(negedge clk);

      // WIDTH=8 signed 0x80*0x80.
      lat8 = -1;
      @(posedge clk); #1; a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
      @(posedge clk); #1; start8 = 1'b0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (done8) begin lat8 = k; break; end
      end
      checkOutput("w8_latency", 64'(lat8), 64'd9);
      checkOutput("w8_hilo", {hi8, lo8}, 64'h4000);

      checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
